uart_tx_scheduler: RTL

//  Shares the single UART TX path between two requesters: the ALU (16-bit result,

---
 rtl/uart_tx_scheduler_if.sv | 26 ++
 rtl/uart_tx_scheduler.sv | 123 ++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler_if.sv
// Handshake bundle between the ALU/register-file requesters, the TX scheduler and the UART TX.
// master = scheduler side, slave = requesters plus UART TX.
interface uart_tx_scheduler_if #(
  parameter int DATA_WIDTH = 8
);
  logic                    alu_req;
  logic [2*DATA_WIDTH-1:0] alu_data;
  logic                    alu_ack;
  logic                    rf_req;
  logic [DATA_WIDTH-1:0]   rf_data;
  logic                    rf_ack;
  logic                    tx_busy;
  logic                    tx_valid;
  logic [DATA_WIDTH-1:0]   tx_data;
  logic                    sched_busy;

  modport master (
    input  alu_req, alu_data, rf_req, rf_data, tx_busy,
    output alu_ack, rf_ack, tx_valid, tx_data, sched_busy
  );

  modport slave (
    output alu_req, alu_data, rf_req, rf_data, tx_busy,
    input  alu_ack, rf_ack, tx_valid, tx_data, sched_busy
  );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin share of one UART TX between ALU (2 bytes, low first) and register file (1 byte);
// req-to-tx_valid 2 cycles min, holds while tx_busy, re-sends a byte if tx_busy never rises.
module uart_tx_scheduler #(
  parameter int DATA_WIDTH   = 8,
  parameter int BUSY_TIMEOUT = 4
) (
  input logic               clk,
  input logic               rst,
  uart_tx_scheduler_if.master bus
);
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_HI, WAIT_LO} state_t;

  state_t                  state, state_nx;
  logic [2*DATA_WIDTH-1:0] byte_buf, byte_buf_nx;
  logic [1:0]              byte_cnt, byte_cnt_nx;
  logic [TW-1:0]           to_cnt, to_cnt_nx;
  logic                    last_alu, last_alu_nx;  // 1: ALU won the most recent grant
  logic                    alu_ack_q, alu_ack_nx;
  logic                    rf_ack_q, rf_ack_nx;
  logic                    tx_valid_q, tx_valid_nx;
  logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_nx;
  logic                    sched_busy_q, sched_busy_nx;
  logic                    grant_alu;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      byte_buf     <= '0;
      byte_cnt     <= '0;
      to_cnt       <= '0;
      last_alu     <= 1'b0;
      alu_ack_q    <= 1'b0;
      rf_ack_q     <= 1'b0;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= '0;
      sched_busy_q <= 1'b0;
    end else begin
      state        <= state_nx;
      byte_buf     <= byte_buf_nx;
      byte_cnt     <= byte_cnt_nx;
      to_cnt       <= to_cnt_nx;
      last_alu     <= last_alu_nx;
      alu_ack_q    <= alu_ack_nx;
      rf_ack_q     <= rf_ack_nx;
      tx_valid_q   <= tx_valid_nx;
      tx_data_q    <= tx_data_nx;
      sched_busy_q <= sched_busy_nx;
    end
  end

  // On a tie the requester that did not win last time gets the grant.
  assign grant_alu = bus.alu_req && (!bus.rf_req || !last_alu);

  always_comb begin
    state_nx    = state;
    byte_buf_nx = byte_buf;
    byte_cnt_nx = byte_cnt;
    to_cnt_nx   = to_cnt;
    last_alu_nx = last_alu;
    alu_ack_nx  = 1'b0;
    rf_ack_nx   = 1'b0;
    tx_valid_nx = 1'b0;
    tx_data_nx  = tx_data_q;

    case (state)
      IDLE: begin
        if (bus.alu_req || bus.rf_req) begin
          state_nx    = SEND;
          last_alu_nx = grant_alu;
          if (grant_alu) begin
            byte_buf_nx = bus.alu_data;
            byte_cnt_nx = 2'd2;
            alu_ack_nx  = 1'b1;
          end else begin
            byte_buf_nx = {{DATA_WIDTH{1'b0}}, bus.rf_data};
            byte_cnt_nx = 2'd1;
            rf_ack_nx   = 1'b1;
          end
        end
      end
      SEND: begin
        if (!bus.tx_busy) begin
          tx_valid_nx = 1'b1;
          tx_data_nx  = byte_buf[DATA_WIDTH-1:0];
          to_cnt_nx   = '0;
          state_nx    = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (bus.tx_busy) begin
          state_nx = WAIT_LO;
        end else if (to_cnt == TW'(BUSY_TIMEOUT - 1)) begin
          // UART never acknowledged the strobe: offer the same byte again.
          state_nx = SEND;
        end else begin
          to_cnt_nx = to_cnt + TW'(1);
        end
      end
      WAIT_LO: begin
        if (!bus.tx_busy) begin
          byte_cnt_nx = byte_cnt - 2'd1;
          if (byte_cnt == 2'd1) begin
            state_nx = IDLE;
          end else begin
            byte_buf_nx = byte_buf >> DATA_WIDTH;
            state_nx    = SEND;
          end
        end
      end
      default: state_nx = IDLE;
    endcase

    sched_busy_nx = (state_nx != IDLE);
  end

  assign bus.alu_ack    = alu_ack_q;
  assign bus.rf_ack     = rf_ack_q;
  assign bus.tx_valid   = tx_valid_q;
  assign bus.tx_data    = tx_data_q;
  assign bus.sched_busy = sched_busy_q;
endmodule
